lut_ff_mux_resp_checker: RTL and testbench

//   Receiving end of the lut_ff_mux stimulus/compare protocol: a synthesizable response

---
 rtl/lut_ff_mux_resp_checker.sv | 162 ++++++++++++++++
 tb/tb_lut_ff_mux_resp_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lut_ff_mux_resp_checker.sv
// Response checker for the lut_ff_mux golden/netlist compare protocol. Waits a fixed
// settle time after each stimulus strobe, compares golden Q against netlist Q and
// accumulates saturating pass/fail statistics.
module lut_ff_mux_resp_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned TS_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stim_valid,
   input  logic             test_end,
   input  logic             q_golden,
   input  logic             q_netlist,
   output logic             cmp_valid,
   output logic             cmp_match,
   output logic [CNT_W-1:0] compare_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic             first_mm_valid,
   output logic [TS_W-1:0]  first_mm_stamp,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {StIdle, StSettle, StCompare, StDone} state_e;

   localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

   logic [1:0]       rst_sync_q;
   logic             rst_int_n;
   state_e           state_q, state_d;
   logic [7:0]       settle_cnt_q, settle_cnt_d;
   logic             pending_end_q, pending_end_d;
   logic [TS_W-1:0]  cycle_ts_q, cycle_ts_d;
   logic             cmp_valid_q, cmp_valid_d;
   logic             cmp_match_q, cmp_match_d;
   logic [CNT_W-1:0] compare_cnt_q, compare_cnt_d;
   logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
   logic             first_mm_valid_q, first_mm_valid_d;
   logic [TS_W-1:0]  first_mm_stamp_q, first_mm_stamp_d;
   logic             do_cmp;
   logic             mismatch;

   // Reset synchronizer: assertion is immediate, release is aligned to clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   // X/Z on either Q counts as a mismatch in simulation; hardware sees plain inequality.
`ifdef SYNTHESIS
   assign mismatch = (q_golden != q_netlist);
`else
   assign mismatch = (q_golden !== q_netlist);
`endif

   // Next-state logic: FSM sequencing; do_cmp marks the sample edge (SETTLE -> COMPARE).
   always_comb begin
      state_d       = state_q;
      settle_cnt_d  = settle_cnt_q;
      pending_end_d = pending_end_q;
      do_cmp        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (stim_valid) begin
               state_d       = StSettle;
               settle_cnt_d  = SettleLoad;
               pending_end_d = test_end;
            end else if (test_end) begin
               state_d = StDone;
            end
         end
         StSettle: begin
            if (test_end) pending_end_d = 1'b1;
            // A newer stimulus supersedes the one in flight unless the run is closing.
            if (stim_valid && !pending_end_q) begin
               settle_cnt_d = SettleLoad;
            end else if (settle_cnt_q == 8'd0) begin
               state_d = StCompare;
               do_cmp  = 1'b1;
            end else begin
               settle_cnt_d = settle_cnt_q - 8'd1;
            end
         end
         StCompare: begin
            if (stim_valid && !pending_end_q) begin
               state_d       = StSettle;
               settle_cnt_d  = SettleLoad;
               pending_end_d = test_end;
            end else if (pending_end_q || test_end) begin
               state_d = StDone;
            end else begin
               state_d = StIdle;
            end
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // Next-state logic: compare result, saturating statistics and timestamp.
   always_comb begin
      cycle_ts_d       = (&cycle_ts_q) ? cycle_ts_q : cycle_ts_q + 1'b1;
      cmp_valid_d      = do_cmp;
      cmp_match_d      = cmp_match_q;
      compare_cnt_d    = compare_cnt_q;
      mismatch_cnt_d   = mismatch_cnt_q;
      first_mm_valid_d = first_mm_valid_q;
      first_mm_stamp_d = first_mm_stamp_q;
      if (do_cmp) begin
         cmp_match_d = !mismatch;
         if (!(&compare_cnt_q)) compare_cnt_d = compare_cnt_q + 1'b1;
         if (mismatch) begin
            if (!(&mismatch_cnt_q)) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            if (!first_mm_valid_q) begin
               first_mm_valid_d = 1'b1;
               first_mm_stamp_d = cycle_ts_q;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q          <= StIdle;
         settle_cnt_q     <= 8'd0;
         pending_end_q    <= 1'b0;
         cycle_ts_q       <= '0;
         cmp_valid_q      <= 1'b0;
         cmp_match_q      <= 1'b0;
         compare_cnt_q    <= '0;
         mismatch_cnt_q   <= '0;
         first_mm_valid_q <= 1'b0;
         first_mm_stamp_q <= '0;
      end else begin
         state_q          <= state_d;
         settle_cnt_q     <= settle_cnt_d;
         pending_end_q    <= pending_end_d;
         cycle_ts_q       <= cycle_ts_d;
         cmp_valid_q      <= cmp_valid_d;
         cmp_match_q      <= cmp_match_d;
         compare_cnt_q    <= compare_cnt_d;
         mismatch_cnt_q   <= mismatch_cnt_d;
         first_mm_valid_q <= first_mm_valid_d;
         first_mm_stamp_q <= first_mm_stamp_d;
      end
   end

   assign cmp_valid      = cmp_valid_q;
   assign cmp_match      = cmp_match_q;
   assign compare_cnt    = compare_cnt_q;
   assign mismatch_cnt   = mismatch_cnt_q;
   assign first_mm_valid = first_mm_valid_q;
   assign first_mm_stamp = first_mm_stamp_q;
   assign busy           = (state_q == StSettle) || (state_q == StCompare);
   assign done           = (state_q == StDone);
   assign pass           = done && (mismatch_cnt_q == '0) && (compare_cnt_q != '0);

endmodule

// File: tb/tb_lut_ff_mux_resp_checker.sv
// Directed bench for lut_ff_mux_resp_checker: default instance plus a CNT_W=4 instance
// that always sees mismatching Q, used for the saturation case.
module tb_lut_ff_mux_resp_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stim_valid = 1'b0;
   logic        test_end = 1'b0;
   logic        q_golden = 1'b0;
   logic        q_netlist = 1'b0;
   logic        q_netlist_s;

   logic        cmp_valid, cmp_match, first_mm_valid, busy, done, pass;
   logic [15:0] compare_cnt, mismatch_cnt;
   logic [31:0] first_mm_stamp;

   logic        cmp_valid_s, cmp_match_s, first_mm_valid_s, busy_s, done_s, pass_s;
   logic [3:0]  compare_cnt_s, mismatch_cnt_s;
   logic [31:0] first_mm_stamp_s;

   int unsigned cyc;
   int          errors = 0;
   int          checks = 0;
   int unsigned stamp, mm_stamp;

   assign q_netlist_s = ~q_golden;

   always #5 clk = ~clk;

   // Edges since reset release; DUT timestamp lags by its two-stage reset release.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   lut_ff_mux_resp_checker dut (
      .clk(clk), .rst(rst), .stim_valid(stim_valid), .test_end(test_end),
      .q_golden(q_golden), .q_netlist(q_netlist), .cmp_valid(cmp_valid),
      .cmp_match(cmp_match), .compare_cnt(compare_cnt), .mismatch_cnt(mismatch_cnt),
      .first_mm_valid(first_mm_valid), .first_mm_stamp(first_mm_stamp), .busy(busy),
      .done(done), .pass(pass)
   );

   lut_ff_mux_resp_checker #(.CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .stim_valid(stim_valid), .test_end(test_end),
      .q_golden(q_golden), .q_netlist(q_netlist_s), .cmp_valid(cmp_valid_s),
      .cmp_match(cmp_match_s), .compare_cnt(compare_cnt_s), .mismatch_cnt(mismatch_cnt_s),
      .first_mm_valid(first_mm_valid_s), .first_mm_stamp(first_mm_stamp_s), .busy(busy_s),
      .done(done_s), .pass(pass_s)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      stim_valid = 1'b0;
      test_end = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      tick();
      tick();
   endtask

   // One stimulus with 4-clock spacing; cmp_valid must show exactly 3 clocks later.
   task automatic do_stim(input logic mm, input logic use_x, output int unsigned st);
      stim_valid = 1'b1;
      q_golden   = ~q_golden;
      q_netlist  = use_x ? 1'bx : (mm ? ~q_golden : q_golden);
      tick();
      stim_valid = 1'b0;
      check_eq("busy_t1", {31'd0, busy}, 32'd1);
      check_eq("cmp_valid_t1", {31'd0, cmp_valid}, 32'd0);
      tick();
      check_eq("cmp_valid_t2", {31'd0, cmp_valid}, 32'd0);
      tick();
      check_eq("cmp_valid_t3", {31'd0, cmp_valid}, 32'd1);
      check_eq("cmp_match", {31'd0, cmp_match}, {31'd0, !(mm || use_x)});
      st = cyc - 3;
      tick();
      check_eq("cmp_valid_t4", {31'd0, cmp_valid}, 32'd0);
      q_netlist = q_golden;
   endtask

   task automatic end_run();
      test_end = 1'b1;
      tick();
      test_end = 1'b0;
   endtask

   initial begin
      // Test 1: reset state, then test_end with no stimulus.
      do_reset();
      check_eq("rst_compare_cnt", {16'd0, compare_cnt}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_first_mm_valid", {31'd0, first_mm_valid}, 32'd0);
      end_run();
      check_eq("t1_done", {31'd0, done}, 32'd1);
      check_eq("t1_pass", {31'd0, pass}, 32'd0);
      check_eq("t1_compare_cnt", {16'd0, compare_cnt}, 32'd0);
      stim_valid = 1'b1;
      tick();
      stim_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check_eq("t1_done_ignores_stim", {16'd0, compare_cnt}, 32'd0);
      check_eq("t1_done_not_busy", {31'd0, busy}, 32'd0);

      // Test 2: five matching compares.
      do_reset();
      for (int i = 0; i < 5; i++) do_stim(1'b0, 1'b0, stamp);
      end_run();
      check_eq("t2_compare_cnt", {16'd0, compare_cnt}, 32'd5);
      check_eq("t2_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
      check_eq("t2_done", {31'd0, done}, 32'd1);
      check_eq("t2_pass", {31'd0, pass}, 32'd1);

      // Test 3: third of five stimuli mismatches.
      do_reset();
      mm_stamp = 0;
      for (int i = 0; i < 5; i++) begin
         do_stim(i == 2, 1'b0, stamp);
         if (i == 2) mm_stamp = stamp;
      end
      end_run();
      check_eq("t3_compare_cnt", {16'd0, compare_cnt}, 32'd5);
      check_eq("t3_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd1);
      check_eq("t3_first_mm_valid", {31'd0, first_mm_valid}, 32'd1);
      check_eq("t3_first_mm_stamp", first_mm_stamp, mm_stamp);
      check_eq("t3_pass", {31'd0, pass}, 32'd0);

      // Test 4: restart at t+1, test_end at t+2 -> one compare, then DONE.
      do_reset();
      q_netlist = q_golden;
      stim_valid = 1'b1;
      tick();
      tick();
      stim_valid = 1'b0;
      test_end = 1'b1;
      tick();
      test_end = 1'b0;
      check_eq("t4_no_cmp_first", {31'd0, cmp_valid}, 32'd0);
      tick();
      check_eq("t4_cmp_valid", {31'd0, cmp_valid}, 32'd1);
      check_eq("t4_not_done_yet", {31'd0, done}, 32'd0);
      tick();
      check_eq("t4_done", {31'd0, done}, 32'd1);
      check_eq("t4_compare_cnt", {16'd0, compare_cnt}, 32'd1);
      check_eq("t4_pass", {31'd0, pass}, 32'd1);

      // Test 5: X on netlist Q is a mismatch; async reset mid-SETTLE.
      do_reset();
      do_stim(1'b0, 1'b1, stamp);
      check_eq("t5_x_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd1);
      stim_valid = 1'b1;
      tick();
      stim_valid = 1'b0;
      check_eq("t5_busy_before_rst", {31'd0, busy}, 32'd1);
      #2 rst = 1'b0;
      #1;
      check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
      check_eq("t5_rst_compare_cnt", {16'd0, compare_cnt}, 32'd0);
      check_eq("t5_rst_mismatch_cnt", {16'd0, mismatch_cnt}, 32'd0);
      check_eq("t5_rst_first_mm_valid", {31'd0, first_mm_valid}, 32'd0);
      check_eq("t5_rst_first_mm_stamp", first_mm_stamp, 32'd0);
      check_eq("t5_rst_cmp_match", {31'd0, cmp_match}, 32'd0);

      // Test 6: CNT_W=4 instance saturates at 15 after 20 mismatching compares.
      do_reset();
      for (int i = 0; i < 20; i++) do_stim(1'b0, 1'b0, stamp);
      check_eq("t6_sat_compare_cnt", {28'd0, compare_cnt_s}, 32'd15);
      check_eq("t6_sat_mismatch_cnt", {28'd0, mismatch_cnt_s}, 32'd15);
      check_eq("t6_wide_compare_cnt", {16'd0, compare_cnt}, 32'd20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Overall time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
